// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, front-end FSM states and the opcode validity check.
// Both the UART/ALU interface block and the ALU import this package.
package alu_pkg;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_W-1:0] OP_AND = 6'b100100;
  localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
  localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
  localparam logic [OP_W-1:0] OP_SRL = 6'b000010;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    CALC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  function automatic logic is_valid_op(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: is_valid_op = 1'b1;
      default:                        is_valid_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Inter-byte idle counter: counts enabled cycles, saturates at TIMEOUT-1 and flags expiry there.
module frame_timer #(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // Idle count: clear wins, otherwise count up while enabled and hold at the limit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= {CW{1'b0}};
    end else if (i_clear) begin
      r_count <= {CW{1'b0}};
    end else if (i_enable && (r_count != LIMIT)) begin
      r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_expired = i_enable && (r_count == LIMIT);

endmodule

// File: rtl/uart_alu_intf.sv
// Frames three received bytes (A, B, opcode) into ALU operands, then sends the ALU result back.
// Bad opcodes and inter-byte timeouts drop the frame with a one-cycle error pulse.
module uart_alu_intf
  import alu_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic               i_Clock,
  input  logic               i_reset,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_err
);

  logic [1:0]         r_rst_sync;
  logic               w_rst_n;
  state_t             r_state;
  state_t             w_next;
  logic               w_err;
  logic               w_op_ok;
  logic               w_expired;
  logic               w_tmr_en;
  logic               w_tmr_clr;
  logic [NB_DATA-1:0] r_alu_a;
  logic [NB_DATA-1:0] r_alu_b;
  logic [NB_OP-1:0]   r_alu_op;
  logic [NB_DATA-1:0] r_tx_data;
  logic               r_tx_start;
  logic               r_err;

  // Reset asserts immediately but releases two clock edges later.
  always_ff @(posedge i_Clock or negedge i_reset) begin
    if (!i_reset) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_op_ok   = ((i_rx_data >> NB_OP) == {NB_DATA{1'b0}}) && is_valid_op(i_rx_data[NB_OP-1:0]);
  assign w_tmr_en  = (r_state == WAIT_B) || (r_state == WAIT_OP);
  assign w_tmr_clr = i_rx_done || ((w_next != r_state) && ((w_next == WAIT_B) || (w_next == WAIT_OP)));

  frame_timer #(.TIMEOUT(TIMEOUT)) u_frame_timer (
    .i_clk     (i_Clock),
    .i_rst_n   (w_rst_n),
    .i_clear   (w_tmr_clr),
    .i_enable  (w_tmr_en),
    .o_expired (w_expired)
  );

  // A received byte always beats a timeout expiring in the same cycle.
  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    case (r_state)
      WAIT_A: begin
        if (i_rx_done) w_next = WAIT_B;
        else           w_next = WAIT_A;
      end
      WAIT_B: begin
        if (i_rx_done) begin
          w_next = WAIT_OP;
        end else if (w_expired) begin
          w_next = WAIT_A;
          w_err  = 1'b1;
        end else begin
          w_next = WAIT_B;
        end
      end
      WAIT_OP: begin
        if (i_rx_done) begin
          if (w_op_ok) begin
            w_next = CALC;
          end else begin
            w_next = WAIT_A;
            w_err  = 1'b1;
          end
        end else if (w_expired) begin
          w_next = WAIT_A;
          w_err  = 1'b1;
        end else begin
          w_next = WAIT_OP;
        end
      end
      CALC:    w_next = SEND;
      SEND:    w_next = WAIT_TX;
      WAIT_TX: begin
        if (i_tx_done) w_next = WAIT_A;
        else           w_next = WAIT_TX;
      end
      default: w_next = WAIT_A;
    endcase
  end

  always_ff @(posedge i_Clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= WAIT_A;
      r_alu_a    <= {NB_DATA{1'b0}};
      r_alu_b    <= {NB_DATA{1'b0}};
      r_alu_op   <= {NB_OP{1'b0}};
      r_tx_data  <= {NB_DATA{1'b0}};
      r_tx_start <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_tx_start <= (w_next == SEND);
      r_err      <= w_err;
      if ((r_state == WAIT_A) && i_rx_done) r_alu_a <= i_rx_data;
      else                                  r_alu_a <= r_alu_a;
      if ((r_state == WAIT_B) && i_rx_done) r_alu_b <= i_rx_data;
      else                                  r_alu_b <= r_alu_b;
      if ((r_state == WAIT_OP) && i_rx_done && w_op_ok) r_alu_op <= i_rx_data[NB_OP-1:0];
      else                                              r_alu_op <= r_alu_op;
      if (r_state == CALC) r_tx_data <= i_alu_result;
      else                 r_tx_data <= r_tx_data;
    end
  end

  assign o_alu_a    = r_alu_a;
  assign o_alu_b    = r_alu_b;
  assign o_alu_op   = r_alu_op;
  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;
  assign o_err      = r_err;

endmodule

// File: tb/tb_uart_alu_intf.sv
// Directed frames into uart_alu_intf; expected tx bytes / error pulses go to a scoreboard
// queue with the cycle they must appear in, and a negedge monitor pops and compares them.
module tb_uart_alu_intf;

  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int TIMEOUT = 100;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               rx_done = 1'b0;
  logic [NB_DATA-1:0] rx_data = 8'h00;
  logic               tx_done = 1'b0;
  logic [NB_DATA-1:0] alu_res;
  logic [NB_DATA-1:0] o_alu_a, o_alu_b, o_tx_data;
  logic [NB_OP-1:0]   o_alu_op;
  logic               o_tx_start, o_err;

  uart_alu_intf #(.NB_DATA(NB_DATA), .NB_OP(NB_OP), .TIMEOUT(TIMEOUT)) dut (
    .i_Clock      (clk),
    .i_reset      (rst_n),
    .i_rx_done    (rx_done),
    .i_rx_data    (rx_data),
    .i_alu_result (alu_res),
    .i_tx_done    (tx_done),
    .o_alu_a      (o_alu_a),
    .o_alu_b      (o_alu_b),
    .o_alu_op     (o_alu_op),
    .o_tx_start   (o_tx_start),
    .o_tx_data    (o_tx_data),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU sitting downstream of the block.
  always_comb begin
    case (o_alu_op)
      6'b100000: alu_res = o_alu_a + o_alu_b;
      6'b100010: alu_res = o_alu_a - o_alu_b;
      6'b100100: alu_res = o_alu_a & o_alu_b;
      6'b100101: alu_res = o_alu_a | o_alu_b;
      6'b100110: alu_res = o_alu_a ^ o_alu_b;
      6'b100111: alu_res = ~(o_alu_a | o_alu_b);
      6'b000011: alu_res = $unsigned($signed(o_alu_a) >>> o_alu_b[2:0]);
      6'b000010: alu_res = o_alu_a >> o_alu_b[2:0];
      default:   alu_res = 8'h00;
    endcase
  end

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t push_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   last_e = 0;
  int   e0 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every tx_start or err pulse must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (o_tx_start || o_err) begin
        if (sb.size() == 0) begin
          chk("unexpected_event", {30'd0, o_err, o_tx_start}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("event_kind", {30'd0, o_err, o_tx_start}, mon_e.is_err ? 32'd2 : 32'd1);
          chk("event_cycle", cyc, mon_e.at);
          if (!mon_e.is_err) chk("tx_data", {24'd0, o_tx_data}, {24'd0, mon_e.data});
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clk);
    #1;
    rx_done = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1;
    last_e  = cyc;
    rx_done = 1'b0;
  endtask

  task automatic expect_tx(input logic [7:0] d);
    push_e.is_err = 1'b0;
    push_e.data   = d;
    push_e.at     = last_e + 1;
    sb.push_back(push_e);
  endtask

  task automatic expect_err(input int at);
    push_e.is_err = 1'b1;
    push_e.data   = 8'h00;
    push_e.at     = at;
    sb.push_back(push_e);
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    send(a, 1);
    send(b, 1);
    send(op, 1);
  endtask

  task automatic tx_ack();
    repeat (3) @(posedge clk);
    #1 tx_done = 1'b1;
    @(posedge clk);
    #1 tx_done = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return {o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_err};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", all_outs(), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Basic ADD with latency check.
    frame(8'd22, 8'd18, 8'h20); expect_tx(8'd40); tx_ack();
    // SUB then XOR back to back.
    frame(8'h0F, 8'h03, 8'h22); expect_tx(8'h0C); tx_ack();
    frame(8'hF0, 8'h0F, 8'h26); expect_tx(8'hFF); tx_ack();

    // Invalid opcodes: low bits unknown, then valid low bits with upper bits set.
    frame(8'd1, 8'd2, 8'h3F); expect_err(last_e);
    repeat (3) @(posedge clk);
    chk("op_kept_3f", {26'd0, o_alu_op}, 32'h26);
    chk("a_latched", {24'd0, o_alu_a}, 32'd1);
    frame(8'd3, 8'd4, 8'h60); expect_err(last_e);
    repeat (3) @(posedge clk);
    chk("op_kept_60", {26'd0, o_alu_op}, 32'h26);
    frame(8'd5, 8'd3, 8'h24); expect_tx(8'h01); tx_ack();

    // Timeout after A only, then a fresh frame.
    send(8'h11, 1); expect_err(last_e + TIMEOUT);
    repeat (105) @(posedge clk);
    frame(8'h80, 8'h03, 8'h02); expect_tx(8'h10); tx_ack();

    // Byte arriving on the expiring cycle is accepted without error.
    send(8'h21, 1);
    e0 = last_e;
    send(8'h02, TIMEOUT - 1);
    chk("late_b_cycle", last_e - e0, TIMEOUT);
    send(8'h20, 1); expect_tx(8'h23); tx_ack();

    // Bytes in WAIT_TX are dropped, including one coincident with tx_done.
    frame(8'h30, 8'h05, 8'h22); expect_tx(8'h2B);
    repeat (3) @(posedge clk);
    send(8'h55, 1);
    repeat (2) @(posedge clk);
    chk("wait_tx_a_kept", {24'd0, o_alu_a}, 32'h30);
    @(posedge clk);
    #1;
    rx_done = 1'b1; rx_data = 8'h66; tx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0; tx_done = 1'b0;
    chk("coincident_a_kept", {24'd0, o_alu_a}, 32'h30);
    send(8'h77, 1);
    chk("a_after_tx", {24'd0, o_alu_a}, 32'h77);
    send(8'h01, 1); send(8'h25, 1); expect_tx(8'h77); tx_ack();

    // Reset after B aborts the frame; the next bytes start over as A.
    send(8'h05, 1); send(8'h06, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_outputs", all_outs(), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midreset_hold", all_outs(), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    frame(8'h07, 8'h08, 8'h20); expect_tx(8'h0F); tx_ack();

    repeat (10) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
